vid_timing_gen: RTL



---
 rtl/vtg_pkg.sv | 28 ++
 rtl/vtg_delay_line.sv | 37 +++
 rtl/vid_timing_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vtg_pkg.sv
// Shared constants, default raster parameters and FSM state type for the
// video timing generator.
package vtg_pkg;

    localparam int CNT_W = 13;

    localparam int H_NUM_DEF  = 1920;
    localparam int H_FP_DEF   = 88;
    localparam int H_SYNC_DEF = 44;
    localparam int H_BP_DEF   = 148;
    localparam int V_NUM_DEF  = 1080;
    localparam int V_FP_DEF   = 4;
    localparam int V_SYNC_DEF = 5;
    localparam int V_BP_DEF   = 36;

    function automatic int vtg_total(input int sync_w, input int bp, input int act, input int fp);
        return sync_w + bp + act + fp;
    endfunction

    localparam int H_TOT = vtg_total(H_SYNC_DEF, H_BP_DEF, H_NUM_DEF, H_FP_DEF);
    localparam int V_TOT = vtg_total(V_SYNC_DEF, V_BP_DEF, V_NUM_DEF, V_FP_DEF);

    typedef enum logic {
        WAIT_INIT = 1'b0,
        RUN       = 1'b1
    } vtg_state_t;

endpackage

// File: rtl/vtg_delay_line.sv
// Parameterised shift register with synchronous clear; DEPTH=0 is a
// straight wire.
module vtg_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, clk, srst};
            assign o_data      = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        if (srst) r_stage[gi] <= '0;
                        else      r_stage[gi] <= i_data;
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        if (srst) r_stage[gi] <= '0;
                        else      r_stage[gi] <= r_stage[gi-1];
                    end
                end
            end
            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing generator for the vout_clk domain. Optional frame counter
// output is enabled by defining VTG_FRAME_CNT_EN.
module vid_timing_gen
    import vtg_pkg::*;
#(
    parameter int H_NUM  = H_NUM_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_NUM  = V_NUM_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF,
    parameter int DE_LAT = 2
) (
    input  logic             vout_clk,
    input  logic             vout_rst,
    input  logic             init_done,
    output logic             rd_fsync,
    output logic             rd_en,
    output logic [CNT_W-1:0] act_x,
    output logic [CNT_W-1:0] act_y,
    output logic             hs_out,
`ifdef VTG_FRAME_CNT_EN
    output logic [7:0]       frame_cnt,
`endif
    output logic             vs_out
);

    localparam int LINE_TOT  = vtg_total(H_SYNC, H_BP, H_NUM, H_FP);
    localparam int FRAME_TOT = vtg_total(V_SYNC, V_BP, V_NUM, V_FP);

    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(LINE_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(FRAME_TOT - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_SYNC + H_BP + H_NUM);
    localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_SYNC + V_BP + V_NUM);

    vtg_state_t       r_state, w_state_next;
    logic             r_init_meta, r_init_sync;
    logic [CNT_W-1:0] r_h_cnt, r_v_cnt, w_h_next, w_v_next;
    logic             w_run, w_h_last, w_v_last, w_de, w_hs, w_vs;
    logic [1:0]       w_sync_dly;
    logic             r_rd_en, r_rd_fsync, r_hs_out, r_vs_out;
    logic [CNT_W-1:0] r_act_x, r_act_y;

    // init_done comes from the DDR controller's clock domain
    always_ff @(posedge vout_clk) begin
        if (vout_rst) begin
            r_init_meta <= 1'b0;
            r_init_sync <= 1'b0;
        end else begin
            r_init_meta <= init_done;
            r_init_sync <= r_init_meta;
        end
    end

    always_ff @(posedge vout_clk) begin
        if (vout_rst) begin
            r_state <= WAIT_INIT;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
        end
    end

    assign w_run    = (r_state == RUN);
    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    always_comb begin
        w_state_next = r_state;
        w_h_next     = r_h_cnt;
        w_v_next     = r_v_cnt;
        case (r_state)
            WAIT_INIT: begin
                w_h_next = '0;
                w_v_next = '0;
                if (r_init_sync) w_state_next = RUN;
            end
            RUN: begin
                if (w_h_last) begin
                    w_h_next = '0;
                    w_v_next = w_v_last ? '0 : r_v_cnt + 1'b1;
                end else begin
                    w_h_next = r_h_cnt + 1'b1;
                end
            end
            default: w_state_next = WAIT_INIT;
        endcase
    end

    assign w_de = w_run && (r_h_cnt >= H_ACT_START) && (r_h_cnt < H_ACT_END)
                        && (r_v_cnt >= V_ACT_START) && (r_v_cnt < V_ACT_END);
    assign w_hs = w_run && (r_h_cnt < H_SYNC_END);
    assign w_vs = w_run && (r_v_cnt < V_SYNC_END);

    // Sync is pre-delayed so it lands with the read buffer's returned pixels
    vtg_delay_line #(
        .WIDTH (2),
        .DEPTH (DE_LAT)
    ) u_sync_dly (
        .clk    (vout_clk),
        .srst   (vout_rst),
        .i_data ({w_vs, w_hs}),
        .o_data (w_sync_dly)
    );

    always_ff @(posedge vout_clk) begin
        if (vout_rst) begin
            r_rd_en    <= 1'b0;
            r_rd_fsync <= 1'b0;
            r_act_x    <= '0;
            r_act_y    <= '0;
            r_hs_out   <= 1'b0;
            r_vs_out   <= 1'b0;
        end else begin
            r_rd_en    <= w_de;
            r_rd_fsync <= w_vs;
            r_act_x    <= w_de ? (r_h_cnt - H_ACT_START) : '0;
            r_act_y    <= w_de ? (r_v_cnt - V_ACT_START) : '0;
            r_hs_out   <= w_sync_dly[0];
            r_vs_out   <= w_sync_dly[1];
        end
    end

    assign rd_en    = r_rd_en;
    assign rd_fsync = r_rd_fsync;
    assign act_x    = r_act_x;
    assign act_y    = r_act_y;
    assign hs_out   = r_hs_out;
    assign vs_out   = r_vs_out;

`ifdef VTG_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge vout_clk) begin
        if (vout_rst)                         r_frame_cnt <= '0;
        else if (w_run && w_h_last && w_v_last) r_frame_cnt <= r_frame_cnt + 1'b1;
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
